// File: rtl/cache_manage_unit_pkg.sv
// rtl/cache_manage_unit_pkg.sv - shared state encodings and address field geometry for the cache manager
package cache_manage_unit_pkg;

  // Controller states: idle/hit service, victim write-back, line refill, retry settle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BACK = 2'd1,
    S_FILL = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  // Address geometry: {tag, set index, word-in-line, byte offset}.
  localparam int CMU_ADDR_BITS  = 32;
  localparam int CMU_TAG_BITS   = 23;
  localparam int CMU_LINE_WORDS = 4;
  localparam int BYTE_OFS_BITS  = 2;

endpackage

// File: rtl/cache_manage_unit.sv
// rtl/cache_manage_unit.sv - CPU-to-cache controller with dirty write-back and line refill
module cache_manage_unit
  import cache_manage_unit_pkg::*;
#(
  parameter int ADDR_BITS  = CMU_ADDR_BITS,
  parameter int TAG_BITS   = CMU_TAG_BITS,
  parameter int LINE_WORDS = CMU_LINE_WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_r,
  input  logic                 en_w,
  input  logic [ADDR_BITS-1:0] addr_rw,
  input  logic [2:0]           u_b_h_w,
  input  logic [31:0]          data_w,
  output logic [31:0]          data_r,
  output logic                 stall,
  output logic [6:0]           cache_req_o,
  output logic [ADDR_BITS-1:0] cache_addr_o,
  output logic [31:0]          cache_din_o,
  input  logic                 cache_hit_i,
  input  logic                 cache_valid_i,
  input  logic                 cache_dirty_i,
  input  logic [TAG_BITS-1:0]  cache_tag_i,
  input  logic [31:0]          cache_dout_i,
  output logic                 mem_cs_o,
  output logic                 mem_we_o,
  output logic [ADDR_BITS-1:0] mem_addr_o,
  output logic [31:0]          mem_data_o,
  input  logic [31:0]          mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int WC_BITS  = $clog2(LINE_WORDS);
  localparam int IDX_BITS = ADDR_BITS - TAG_BITS - WC_BITS - BYTE_OFS_BITS;
  localparam logic [WC_BITS-1:0] LAST_WORD = WC_BITS'(LINE_WORDS - 1);

  state_t               state, state_nx;
  logic [WC_BITS-1:0]   word_cnt, word_cnt_nx;
  logic                 primed, primed_nx;
  logic                 checked, checked_nx;
  logic [TAG_BITS-1:0]  victim_tag, victim_tag_nx;
  logic [TAG_BITS-1:0]  req_tag, req_tag_nx;
  logic [IDX_BITS-1:0]  idx, idx_nx;
  logic                 c_load, c_store, c_edit;
  logic                 last_word;

  function automatic logic [ADDR_BITS-1:0] line_addr(input logic [TAG_BITS-1:0] tag,
                                                     input logic [IDX_BITS-1:0] set_idx,
                                                     input logic [WC_BITS-1:0]  wc);
    return {tag, set_idx, wc, {BYTE_OFS_BITS{1'b0}}};
  endfunction

  assign last_word = (word_cnt == LAST_WORD);

  // State, word counter, priming flag and the latched miss context.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      word_cnt   <= '0;
      primed     <= 1'b0;
      checked    <= 1'b0;
      victim_tag <= '0;
      req_tag    <= '0;
      idx        <= '0;
    end else begin
      state      <= state_nx;
      word_cnt   <= word_cnt_nx;
      primed     <= primed_nx;
      checked    <= checked_nx;
      victim_tag <= victim_tag_nx;
      req_tag    <= req_tag_nx;
      idx        <= idx_nx;
    end
  end

  // Next-state and all cache/memory/CPU outputs; outputs are forced quiet while in reset.
  always_comb begin
    state_nx      = state;
    word_cnt_nx   = word_cnt;
    primed_nx     = primed;
    checked_nx    = checked;
    victim_tag_nx = victim_tag;
    req_tag_nx    = req_tag;
    idx_nx        = idx;
    c_load        = 1'b0;
    c_store       = 1'b0;
    c_edit        = 1'b0;
    cache_addr_o  = addr_rw;
    cache_din_o   = data_w;
    data_r        = '0;
    stall         = 1'b0;
    mem_cs_o      = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_data_o    = '0;

    case (state)
      S_IDLE: begin
        c_load = en_r;
        if (en_r || en_w) begin
          if (!checked) begin
            // Flags for this address are not back from the cache yet.
            stall      = 1'b1;
            checked_nx = 1'b1;
          end else begin
            checked_nx = 1'b0;
            if (cache_hit_i) begin
              data_r = cache_dout_i;
              c_edit = en_w;
            end else begin
              stall         = 1'b1;
              victim_tag_nx = cache_tag_i;
              req_tag_nx    = addr_rw[ADDR_BITS-1 -: TAG_BITS];
              idx_nx        = addr_rw[BYTE_OFS_BITS+WC_BITS +: IDX_BITS];
              word_cnt_nx   = '0;
              primed_nx     = 1'b0;
              state_nx      = (cache_valid_i && cache_dirty_i) ? S_BACK : S_FILL;
            end
          end
        end else begin
          checked_nx = 1'b0;
        end
      end

      S_BACK: begin
        // load=0 makes the cache present the LRU way, i.e. the victim line.
        stall        = 1'b1;
        cache_addr_o = line_addr('0, idx, word_cnt);
        if (!primed) begin
          primed_nx = 1'b1;
        end else begin
          mem_cs_o   = 1'b1;
          mem_we_o   = 1'b1;
          mem_addr_o = line_addr(victim_tag, idx, word_cnt);
          mem_data_o = cache_dout_i;
          if (mem_ack_i) begin
            word_cnt_nx = word_cnt + WC_BITS'(1);
            primed_nx   = 1'b0;
            if (last_word) state_nx = S_FILL;
          end
        end
      end

      S_FILL: begin
        stall        = 1'b1;
        mem_cs_o     = 1'b1;
        mem_addr_o   = line_addr(req_tag, idx, word_cnt);
        cache_addr_o = line_addr(req_tag, idx, word_cnt);
        if (mem_ack_i) begin
          c_store     = 1'b1;
          cache_din_o = mem_data_i;
          word_cnt_nx = word_cnt + WC_BITS'(1);
          if (last_word) state_nx = S_WAIT;
        end
      end

      S_WAIT: begin
        // Re-present the CPU address so the retry in S_IDLE sees fresh flags.
        stall      = 1'b1;
        c_load     = en_r;
        checked_nx = 1'b1;
        state_nx   = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase

    cache_req_o = {c_load, c_store, c_edit, 1'b0, u_b_h_w};

    if (rst) begin
      cache_req_o  = '0;
      cache_addr_o = '0;
      cache_din_o  = '0;
      data_r       = '0;
      stall        = 1'b0;
      mem_cs_o     = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
    end
  end

endmodule

// File: tb/tb_cache_manage_unit.sv
// tb/tb_cache_manage_unit.sv - self-checking bench with cache and memory models for cache_manage_unit
module tb_cache_manage_unit;
  import cache_manage_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_r, en_w;
  logic [31:0] addr_rw;
  logic [2:0]  u_b_h_w;
  logic [31:0] data_w;
  logic [31:0] data_r;
  logic        stall;
  logic [6:0]  cache_req_o;
  logic [31:0] cache_addr_o, cache_din_o;
  logic        cache_hit_i, cache_valid_i, cache_dirty_i;
  logic [22:0] cache_tag_i;
  logic [31:0] cache_dout_i;
  logic        mem_cs_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  logic        mem_ack_i;

  cache_manage_unit dut (
    .clk(clk), .rst(rst), .en_r(en_r), .en_w(en_w), .addr_rw(addr_rw),
    .u_b_h_w(u_b_h_w), .data_w(data_w), .data_r(data_r), .stall(stall),
    .cache_req_o(cache_req_o), .cache_addr_o(cache_addr_o), .cache_din_o(cache_din_o),
    .cache_hit_i(cache_hit_i), .cache_valid_i(cache_valid_i), .cache_dirty_i(cache_dirty_i),
    .cache_tag_i(cache_tag_i), .cache_dout_i(cache_dout_i),
    .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Two-way cache model with registered flags/data and recent-bit LRU.
  logic [22:0] tg  [32][2];
  logic        vb  [32][2];
  logic        db  [32][2];
  logic        rec [32];
  logic [31:0] dat [32][2][4];
  logic [4:0]  m_s;
  logic [22:0] m_t;
  logic [1:0]  m_w;
  logic        m_h0, m_h1, m_hit, m_hw, m_lru;
  logic [31:0] m_wd;

  always @(posedge clk) begin
    m_s   = cache_addr_o[8:4];
    m_t   = cache_addr_o[31:9];
    m_w   = cache_addr_o[3:2];
    m_h0  = vb[m_s][0] && (tg[m_s][0] == m_t);
    m_h1  = vb[m_s][1] && (tg[m_s][1] == m_t);
    m_hit = m_h0 || m_h1;
    m_hw  = m_h1;
    m_lru = ~rec[m_s];
    cache_hit_i   <= m_hit;
    cache_valid_i <= vb[m_s][m_lru];
    cache_dirty_i <= db[m_s][m_lru];
    cache_tag_i   <= tg[m_s][m_lru];
    if (cache_req_o[6] && m_hit)  cache_dout_i <= dat[m_s][m_hw][m_w];
    else if (!cache_req_o[6])     cache_dout_i <= dat[m_s][m_lru][m_w];
    else                          cache_dout_i <= 32'h0;
    if (cache_req_o[6] && m_hit) rec[m_s] = m_hw;
    if (cache_req_o[4] && m_hit) begin
      m_wd = dat[m_s][m_hw][m_w];
      case (cache_req_o[1:0])
        2'b00:   m_wd[cache_addr_o[1:0]*8 +: 8] = cache_din_o[7:0];
        2'b01:   m_wd[cache_addr_o[1]*16 +: 16] = cache_din_o[15:0];
        default: m_wd = cache_din_o;
      endcase
      dat[m_s][m_hw][m_w] = m_wd;
      db[m_s][m_hw] = 1'b1;
      rec[m_s] = m_hw;
    end
    if (cache_req_o[5]) begin
      dat[m_s][m_lru][m_w] = cache_din_o;
      tg[m_s][m_lru] = m_t;
      vb[m_s][m_lru] = 1'b1;
      db[m_s][m_lru] = 1'b0;
    end
  end

  // Memory model with programmable ack latency and an expected-transaction scoreboard.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_exp_t;

  mem_exp_t    mem_q [$];
  logic [31:0] mem [1024];
  int          mem_delay = 0;
  int          ack_cnt   = 0;
  int          fill_acks = 0;
  logic        prev_cs = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_addr = '0, prev_data = '0;
  mem_exp_t    m_e;

  always @(posedge clk) begin
    if (mem_ack_i && mem_cs_o) begin
      if (mem_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mem_unexpected: got access %h want none", mem_addr_o);
      end else begin
        m_e = mem_q.pop_front();
        check("mem_we", {31'b0, mem_we_o}, {31'b0, m_e.we});
        check("mem_addr", mem_addr_o, m_e.addr);
        if (m_e.we) check("mem_wdata", mem_data_o, m_e.data);
        else fill_acks++;
      end
      if (mem_we_o) mem[mem_addr_o[11:2]] = mem_data_o;
    end
    if (mem_cs_o && prev_cs && !prev_ack) begin
      check("mem_addr_stable", mem_addr_o, prev_addr);
      check("mem_data_stable", mem_data_o, prev_data);
    end
    prev_cs   = mem_cs_o;
    prev_ack  = mem_ack_i;
    prev_addr = mem_addr_o;
    prev_data = mem_data_o;
    if (mem_ack_i) begin
      mem_ack_i <= 1'b0;
    end else if (mem_cs_o) begin
      if (ack_cnt >= mem_delay) begin
        mem_ack_i  <= 1'b1;
        mem_data_i <= mem_we_o ? 32'h0 : mem[mem_addr_o[11:2]];
        ack_cnt = 0;
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  ubhw;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_stall;
  } vec_t;

  logic [31:0] rd_q [$];

  task automatic push_line(input logic we, input logic [31:0] base, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] dv [4];
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    for (int i = 0; i < 4; i++) begin
      mem_exp_t e;
      e.we = we;
      e.addr = base + 32'(i * 4);
      e.data = dv[i];
      mem_q.push_back(e);
    end
  endtask

  task automatic access(input vec_t v, input string name);
    int          cyc;
    bit          done;
    bit          edit_early;
    logic [31:0] exp_rd;
    @(negedge clk);
    en_r = !v.wr; en_w = v.wr; addr_rw = v.addr; u_b_h_w = v.ubhw; data_w = v.wdata;
    if (!v.wr) rd_q.push_back(v.exp_rd);
    cyc = 0; done = 0; edit_early = 0;
    while (!done && cyc < 500) begin
      #1;
      if (!stall) begin
        done = 1;
        check({name, "_edit"}, {31'b0, cache_req_o[4]}, {31'b0, v.wr});
        check({name, "_inv"}, {31'b0, cache_req_o[3]}, 32'h0);
        if (!v.wr) begin
          exp_rd = rd_q.pop_front();
          check({name, "_data"}, data_r, exp_rd);
        end
      end else begin
        if (cache_req_o[4]) edit_early = 1;
        cyc++;
        @(negedge clk);
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got stall after %0d cycles want release", name, cyc);
    end
    check({name, "_stall_cycles"}, 32'(cyc), 32'(v.exp_stall));
    check({name, "_edit_early"}, {31'b0, edit_early}, 32'h0);
    @(negedge clk);
    en_r = 1'b0; en_w = 1'b0;
    check({name, "_memq_empty"}, 32'(mem_q.size()), 32'h0);
  endtask

  vec_t tbl [8];

  initial begin
    rst = 1'b1; en_r = 0; en_w = 0; addr_rw = 0; u_b_h_w = 0; data_w = 0;
    mem_ack_i = 0; mem_data_i = 0;
    for (int s = 0; s < 32; s++) begin
      rec[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        vb[s][w] = 0; db[s][w] = 0; tg[s][w] = '0;
        for (int k = 0; k < 4; k++) dat[s][w][k] = '0;
      end
    end
    for (int i = 0; i < 1024; i++) mem[i] = 32'h5000_0000 | 32'(i * 4);
    // Set 16: way0 holds 0x100 (tag 0), way1 holds 0x700 (tag 3).
    vb[16][0] = 1; tg[16][0] = 23'd0;
    vb[16][1] = 1; tg[16][1] = 23'd3;
    for (int k = 0; k < 4; k++) begin
      dat[16][0][k] = 32'h1111_0000 | 32'(k);
      dat[16][1][k] = 32'h2222_0000 | 32'(k);
    end

    tbl[0] = '{1'b0, 32'h104, 3'b010, 32'h0,         32'h1111_0001, 1};
    tbl[1] = '{1'b0, 32'h70C, 3'b010, 32'h0,         32'h2222_0003, 1};
    tbl[2] = '{1'b1, 32'h103, 3'b000, 32'h0000_00AB, 32'h0,         1};
    tbl[3] = '{1'b0, 32'h100, 3'b010, 32'h0,         32'hAB11_0000, 1};
    tbl[4] = '{1'b1, 32'h708, 3'b010, 32'hDEAD_BEEF, 32'h0,         1};
    tbl[5] = '{1'b0, 32'h708, 3'b010, 32'h0,         32'hDEAD_BEEF, 1};
    tbl[6] = '{1'b1, 32'h106, 3'b001, 32'h0000_5A5A, 32'h0,         1};
    tbl[7] = '{1'b0, 32'h104, 3'b010, 32'h0,         32'h5A5A_0001, 1};

    repeat (3) @(negedge clk);
    #1;
    check("rst_state", 32'(dut.state), 32'(S_IDLE));
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_mem_cs", {31'b0, mem_cs_o}, 32'h0);
    check("rst_cache_req", {25'b0, cache_req_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_stall", {31'b0, stall}, 32'h0);
    check("post_rst_mem_cs", {31'b0, mem_cs_o}, 32'h0);

    // Hits: reads, byte/half/word writes and read-back.
    for (int i = 0; i < 8; i++) access(tbl[i], $sformatf("hit%0d", i));

    // Clean miss on empty set 0.
    mem_delay = 0;
    push_line(1'b0, 32'h200, 32'h0, 32'h0, 32'h0, 32'h0);
    access('{1'b0, 32'h200, 3'b010, 32'h0, 32'h5000_0200, 11}, "clean_miss");
    access('{1'b0, 32'h20C, 3'b010, 32'h0, 32'h5000_020C, 1}, "clean_after");

    // Dirty eviction of LRU way1 (tag 3) in set 16, then refill from 0x900.
    push_line(1'b1, 32'h700, 32'h2222_0000, 32'h2222_0001, 32'hDEAD_BEEF, 32'h2222_0003);
    push_line(1'b0, 32'h900, 32'h0, 32'h0, 32'h0, 32'h0);
    access('{1'b0, 32'h904, 3'b010, 32'h0, 32'h5000_0904, 23}, "dirty_miss");

    // Slow memory: evict edited way0 (tag 0) and refill 0x300 with 5-cycle ack latency.
    mem_delay = 5;
    push_line(1'b1, 32'h100, 32'hAB11_0000, 32'h5A5A_0001, 32'h1111_0002, 32'h1111_0003);
    push_line(1'b0, 32'h300, 32'h0, 32'h0, 32'h0, 32'h0);
    access('{1'b0, 32'h300, 3'b010, 32'h0, 32'h5000_0300, 63}, "slow_miss");
    check("wb_mem_word1", mem[32'h104 >> 2], 32'h5A5A_0001);

    // Reset while the refill is on word 2.
    mem_delay = 0;
    fill_acks = 0;
    push_line(1'b0, 32'hA00, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    en_r = 1'b1; addr_rw = 32'hA00; u_b_h_w = 3'b010;
    for (int c = 0; c < 100 && fill_acks < 2; c++) @(negedge clk);
    check("fill2_acks", 32'(fill_acks), 32'd2);
    check("fill2_state", 32'(dut.state), 32'(S_FILL));
    check("fill2_word", 32'(dut.word_cnt), 32'd2);
    rst = 1'b1; en_r = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_state", 32'(dut.state), 32'(S_IDLE));
    check("midrst_stall", {31'b0, stall}, 32'h0);
    check("midrst_mem_cs", {31'b0, mem_cs_o}, 32'h0);
    rst = 1'b0;
    mem_q.delete();
    @(negedge clk);
    #1;
    check("after_rst_stall", {31'b0, stall}, 32'h0);
    check("after_rst_mem_cs", {31'b0, mem_cs_o}, 32'h0);
    access('{1'b0, 32'h208, 3'b010, 32'h0, 32'h5000_0208, 1}, "after_rst_hit");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
